// File: rtl/run_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : run_monitor_pkg
//  Brief   : Shared state encoding and fail-code values for run_monitor.
//  Revision: 1.0 - initial release
// ============================================================================
package run_monitor_pkg;

   // Monitor phases: core held in reset, core running, and the two verdicts
   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   // Diagnostic codes reported on fail_code
   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_MISMATCH = 2'd1;
   localparam logic [1:0] FC_TIMEOUT  = 2'd2;
   localparam logic [1:0] FC_EARLY    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/run_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : sat_counter
//  Brief   : Up-counter that stops at LIMIT and flags when it is there.
//  Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 8,
   parameter int LIMIT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             at_limit
);

   localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);

   logic [WIDTH-1:0] r_count;

   // Count enabled cycles, holding at the limit instead of wrapping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable && (r_count != C_LIMIT)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign count    = r_count;
   assign at_limit = (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/run_monitor.sv
`default_nettype none
// ============================================================================
//  Module  : run_monitor
//  Brief   : Holds the core in reset for a programmable delay, then checks
//            every M-stage store against an ordered expected-store table and
//            reports a sticky pass/fail verdict with a diagnostic code.
//  Revision: 1.0 - initial release
// ============================================================================
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int RESET_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 300,
   parameter int NUM_EXP        = 8,
   parameter int IDX_W          = $clog2(NUM_EXP + 1)
) (
   input  logic                                clk,
   input  logic                                reset,
   output logic                                core_reset,
   input  logic                                MemWriteM,
   input  logic [ADDR_W-1:0]                   DataAdrM,
   input  logic [DATA_W-1:0]                   WriteDataM,
   output logic [IDX_W-1:0]                    exp_idx,
   input  logic [ADDR_W-1:0]                   exp_addr,
   input  logic [DATA_W-1:0]                   exp_data,
   output logic                                pass,
   output logic                                fail,
   output logic [1:0]                          fail_code,
   output logic [IDX_W-1:0]                    store_count,
   output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] cycle_count,
   output logic [ADDR_W-1:0]                   err_addr,
   output logic [DATA_W-1:0]                   err_data
);

   localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
   localparam int CYC_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [IDX_W-1:0]  C_LAST_IDX  = IDX_W'(NUM_EXP - 1);

   state_t              r_state;
   logic                r_coreReset;
   logic [IDX_W-1:0]    r_storeCount;
   logic                r_pass;
   logic                r_fail;
   logic [1:0]          r_failCode;
   logic [ADDR_W-1:0]   r_errAddr;
   logic [DATA_W-1:0]   r_errData;

   logic [HOLD_W-1:0]   w_holdCount;
   logic                w_holdAtLimit;
   logic                w_holdDone;
   logic [CYC_W-1:0]    w_cycleCount;
   logic                w_cycAtLimit;
   logic                w_storeMatch;
   logic                w_lastEntry;

   // Reset-hold timer: runs only while the core is held
   sat_counter #(
      .WIDTH (HOLD_W),
      .LIMIT (RESET_CYCLES - 1)
   ) u_holdCounter (
      .clk      (clk),
      .reset    (reset),
      .clear    (1'b0),
      .enable   (r_state == ST_HOLD),
      .count    (w_holdCount),
      .at_limit (w_holdAtLimit)
   );

   // Run-cycle timer: runs only in RUN, so it freezes once a verdict is given
   sat_counter #(
      .WIDTH (CYC_W),
      .LIMIT (TIMEOUT_CYCLES - 1)
   ) u_cycleCounter (
      .clk      (clk),
      .reset    (reset),
      .clear    (1'b0),
      .enable   (r_state == ST_RUN),
      .count    (w_cycleCount),
      .at_limit (w_cycAtLimit)
   );

   // Release also triggers past the limit so a corrupted count cannot hold the core forever
   assign w_holdDone   = w_holdAtLimit || (w_holdCount > C_HOLD_LAST);
   assign w_storeMatch = (DataAdrM == exp_addr) && (WriteDataM == exp_data);
   assign w_lastEntry  = (r_storeCount == C_LAST_IDX);

   // Phase control, store checking and verdict latching; verdicts are terminal until reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_HOLD;
         r_coreReset  <= 1'b1;
         r_storeCount <= '0;
         r_pass       <= 1'b0;
         r_fail       <= 1'b0;
         r_failCode   <= FC_NONE;
         r_errAddr    <= '0;
         r_errData    <= '0;
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (MemWriteM) begin
                  r_state     <= ST_FAIL;
                  r_coreReset <= 1'b0;
                  r_fail      <= 1'b1;
                  r_failCode  <= FC_EARLY;
                  r_errAddr   <= DataAdrM;
                  r_errData   <= WriteDataM;
               end else if (w_holdDone) begin
                  r_state     <= ST_RUN;
                  r_coreReset <= 1'b0;
               end
            end
            ST_RUN: begin
               if (MemWriteM && w_storeMatch) begin
                  r_storeCount <= r_storeCount + IDX_W'(1);
                  if (w_lastEntry) begin
                     // A completing store beats a coincident timeout
                     r_state <= ST_PASS;
                     r_pass  <= 1'b1;
                  end else if (w_cycAtLimit) begin
                     r_state    <= ST_FAIL;
                     r_fail     <= 1'b1;
                     r_failCode <= FC_TIMEOUT;
                  end
               end else if (MemWriteM) begin
                  // A mismatch beats a coincident timeout
                  r_state    <= ST_FAIL;
                  r_fail     <= 1'b1;
                  r_failCode <= FC_MISMATCH;
                  r_errAddr  <= DataAdrM;
                  r_errData  <= WriteDataM;
               end else if (w_cycAtLimit) begin
                  r_state    <= ST_FAIL;
                  r_fail     <= 1'b1;
                  r_failCode <= FC_TIMEOUT;
               end
            end
            default: begin
               // PASS and FAIL hold everything until reset
            end
         endcase
      end
   end

   assign core_reset  = r_coreReset;
   assign exp_idx     = r_storeCount;
   assign store_count = r_storeCount;
   assign cycle_count = w_cycleCount;
   assign pass        = r_pass;
   assign fail        = r_fail;
   assign fail_code   = r_failCode;
   assign err_addr    = r_errAddr;
   assign err_data    = r_errData;

endmodule
`default_nettype wire
